// File: rtl/qadd_serial.sv
// Digit-serial sign-magnitude adder: c = a + b, W magnitude bits per cycle,
// valid/ready handshake on both sides, result held until retired.
module qadd_serial #(
    parameter int Q = 15,
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int M  = N - 1;
    localparam int K  = (M + W - 1) / W;
    localparam int KW = K * W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

    if (W < 1 || W > N - 1 || Q > N - 1) begin : g_param_check
        $error("qadd_serial: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   x_q, x_d;
    logic [KW-1:0]   y_q, y_d;
    logic [KW-1:0]   res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sub_q, sub_d;
    logic            sign_q, sign_d;
    logic            carry_q, carry_d;
    logic [N-1:0]    c_q, c_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d;

    logic [M-1:0]    ma_s, mb_s;
    logic            sa_s, sb_s;
    logic            a_gt_b_s;
    logic [W-1:0]    y_chunk_s;
    logic [W:0]      sum_s;
    logic [KW-1:0]   res_next_s;
    logic [KW:0]     full_s;
    logic [M-1:0]    mag_s;

    assign ma_s     = a[M-1:0];
    assign mb_s     = b[M-1:0];
    assign sa_s     = a[N-1];
    assign sb_s     = b[N-1];
    assign a_gt_b_s = (ma_s > mb_s);

    // Subtraction runs as X + ~Y + 1; the +1 is the carry preset at capture.
    assign y_chunk_s  = sub_q ? ~y_q[W-1:0] : y_q[W-1:0];
    assign sum_s      = {1'b0, x_q[W-1:0]} + {1'b0, y_chunk_s} + {{W{1'b0}}, carry_q};
    assign res_next_s = (res_q >> W) | (KW'(sum_s[W-1:0]) << (KW - W));
    assign full_s     = {sum_s[W], res_next_s};
    assign mag_s      = full_s[M-1:0];

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;

    // Next-state and datapath update for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        sub_d       = sub_q;
        sign_d      = sign_q;
        carry_d     = carry_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    res_d   = '0;
                    if (sa_s != sb_s) begin
                        sub_d   = 1'b1;
                        carry_d = 1'b1;
                        if (a_gt_b_s) begin
                            x_d    = KW'(ma_s);
                            y_d    = KW'(mb_s);
                            sign_d = sa_s;
                        end else begin
                            x_d    = KW'(mb_s);
                            y_d    = KW'(ma_s);
                            sign_d = (ma_s == mb_s) ? 1'b0 : sb_s;
                        end
                    end else begin
                        sub_d   = 1'b0;
                        carry_d = 1'b0;
                        x_d     = KW'(ma_s);
                        y_d     = KW'(mb_s);
                        sign_d  = sa_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                x_d     = x_q >> W;
                y_d     = y_q >> W;
                carry_d = sum_s[W];
                res_d   = res_next_s;
                cnt_d   = cnt_q + CW'(1'b1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    c_d         = {((mag_s == '0) ? 1'b0 : sign_q), mag_s};
                    // Pad bits above M are zero on add, so any set bit there is the carry out.
                    ovf_d       = sub_q ? 1'b0 : |full_s[KW:M];
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            sub_q       <= 1'b0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            sign_q      <= sign_d;
            carry_q     <= carry_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_qadd_serial.sv
// Randomized bench for qadd_serial with an arithmetic reference model and a
// per-cycle compare process, plus directed literal vectors.
module tb_qadd_serial;

    localparam int N = 32;
    localparam int Q = 15;
    localparam int W = 8;
    localparam int M = N - 1;
    localparam int K = (M + W - 1) / W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] c;
    logic         ovf;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    qadd_serial #(.Q(Q), .N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c        (c),
        .ovf      (ovf)
    );

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference: returns {ovf, c} from plain integer arithmetic on magnitudes.
    function automatic logic [N:0] model(logic [N-1:0] x, logic [N-1:0] y);
        longint unsigned ma, mb, s, mag;
        logic sgn, ov;
        ma = 64'(x[M-1:0]);
        mb = 64'(y[M-1:0]);
        if (x[N-1] == y[N-1]) begin
            s   = ma + mb;
            ov  = ((s >> M) != 64'd0);
            mag = s & ((64'd1 << M) - 64'd1);
            sgn = x[N-1];
        end else if (ma >= mb) begin
            mag = ma - mb;
            sgn = x[N-1];
            ov  = 1'b0;
        end else begin
            mag = mb - ma;
            sgn = y[N-1];
            ov  = 1'b0;
        end
        if (mag == 64'd0) sgn = 1'b0;
        return {ov, sgn, mag[M-1:0]};
    endfunction

    // Compare process: scoreboard of the one outstanding operation.
    logic         pending = 1'b0;
    int           cyc = 0;
    int           acc_cyc = 0;
    logic [N:0]   exp_r = '0;
    logic [N-1:0] last_c = '0;
    logic         last_ovf = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_c", 64'(c), 64'd0);
                chk("rst_ovf", 64'(ovf), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                pending  = 1'b0;
                last_c   = '0;
                last_ovf = 1'b0;
            end else begin
                chk("in_ready", 64'(in_ready), 64'(!pending));
                if (pending) chk("out_valid", 64'(out_valid), 64'((cyc - acc_cyc) >= K));
                else         chk("out_valid_idle", 64'(out_valid), 64'd0);
                if (out_valid && pending) begin
                    chk("c", 64'(c), 64'(exp_r[N-1:0]));
                    chk("ovf", 64'(ovf), 64'(exp_r[N]));
                end else begin
                    chk("c_hold", 64'(c), 64'(last_c));
                    chk("ovf_hold", 64'(ovf), 64'(last_ovf));
                end
                if (in_valid && in_ready) begin
                    pending = 1'b1;
                    acc_cyc = cyc + 1;
                    exp_r   = model(a, b);
                end else if (out_valid && out_ready) begin
                    pending  = 1'b0;
                    last_c   = exp_r[N-1:0];
                    last_ovf = exp_r[N];
                end
            end
        end
    end

    task automatic do_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input int hold,
                         input logic noise, output logic [N-1:0] rc, output logic ro,
                         output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        if (!in_ready) chk("wait_in_ready_timeout", 64'd0, 64'd1);
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            if (noise) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk); #2;
            guard++;
        end
        lat = guard;
        out_ready = 1'b0;
        in_valid = 1'b0;
        if (!out_valid) chk("wait_out_valid_timeout", 64'd0, 64'd1);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'(h % 2 == 0);
            a = $urandom;
            b = $urandom;
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        rc = c;
        ro = ovf;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rc, ra, rb;
        logic ro;
        int lat;
        int sel;

        // Model pinned against hand-computed values.
        chk("model_add", 64'(model(32'h0000C000, 32'h00012000)), 64'h0_0001E000);
        chk("model_mixed", 64'(model(32'h00008000, 32'h80018000)), 64'h0_80010000);
        chk("model_cancel", 64'(model(32'h00008000, 32'h80008000)), 64'h0_00000000);
        chk("model_wrap", 64'(model(32'hFFFFFFFF, 32'h80000002)), 64'h1_80000001);

        #1;
        chk("in_ready_during_reset", 64'(in_ready), 64'd1);
        chk("out_valid_during_reset", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        do_op(32'h0000C000, 32'h00012000, 0, 1'b0, rc, ro, lat);
        chk("add_c", 64'(rc), 64'h0001E000);
        chk("add_ovf", 64'(ro), 64'd0);
        chk("add_latency", 64'(lat), 64'd4);

        do_op(32'h00008000, 32'h80018000, 1, 1'b0, rc, ro, lat);
        chk("mixed_c", 64'(rc), 64'h80010000);
        do_op(32'h80018000, 32'h00008000, 0, 1'b0, rc, ro, lat);
        chk("mixed_swap_c", 64'(rc), 64'h80010000);

        do_op(32'h00008000, 32'h80008000, 0, 1'b0, rc, ro, lat);
        chk("cancel_c", 64'(rc), 64'h00000000);
        do_op(32'h80000000, 32'h00000000, 0, 1'b0, rc, ro, lat);
        chk("neg_zero_c", 64'(rc), 64'h00000000);

        do_op(32'h7FFFFFFF, 32'h00000001, 0, 1'b0, rc, ro, lat);
        chk("wrap_c", 64'(rc), 64'h00000000);
        chk("wrap_ovf", 64'(ro), 64'd1);

        do_op(32'h00004000, 32'h80002000, 10, 1'b0, rc, ro, lat);
        chk("backpressure_c", 64'(rc), 64'h00002000);
        chk("in_ready_after_retire", 64'(in_ready), 64'd1);

        do_op(32'hFFFFFFFF, 32'h80000002, 0, 1'b0, rc, ro, lat);
        chk("wrap_neg_c", 64'(rc), 64'h80000001);
        chk("wrap_neg_ovf", 64'(ro), 64'd1);

        // Abort during chunk 2 with a nonzero result still held.
        a = 32'h0000C000;
        b = 32'h00012000;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_c", 64'(c), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;

        do_op(32'h00008000, 32'h00008000, 0, 1'b0, rc, ro, lat);
        chk("post_reset_c", 64'(rc), 64'h00010000);
        chk("post_reset_ovf", 64'(ro), 64'd0);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = {~ra[N-1], ra[N-2:0]}; end
                2: begin
                    ra = {1'($urandom_range(0, 1)), {(M-4){1'b1}}, 4'($urandom)};
                    rb = {1'($urandom_range(0, 1)), {(M-4){1'b1}}, 4'($urandom)};
                end
                3: begin ra = {1'($urandom_range(0, 1)), {M{1'b0}}}; rb = $urandom; end
                4: begin ra = $urandom; rb = {ra[N-1], 31'($urandom)}; end
                default: begin
                    ra = {1'($urandom_range(0, 1)), 27'd0, 4'($urandom)};
                    rb = {1'($urandom_range(0, 1)), 27'd0, 4'($urandom)};
                end
            endcase
            do_op(ra, rb, $urandom_range(0, 3), 1'b1, rc, ro, lat);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qadd_serial.md
Name: qadd_serial

Overview:
Multi-cycle sign-magnitude fixed-point adder. It computes c = a + b, which is the additive counterpart of the existing combinational qsubtract. The datapath is digit-serial: W magnitude bits per clock, with a valid/ready handshake on input and output, so it can sit in streaming DSP paths where area matters more than latency. Operand and result format match qsubtract: bit N-1 is the sign, bits N-2:0 are the magnitude, and Q of those are fractional bits.

Parameters:
Q, 15, fractional bits. Interpretation only; does not affect the arithmetic.
N, 32, total word width, including the sign bit.
W, 8, magnitude bits processed per CALC cycle. Legal range 1..N-1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous and active-low.
in_valid  input  1  operands a/b valid.
in_ready  output  1  block can accept operands.
a  input  N  operand A, sign-magnitude.
b  input  N  operand B, sign-magnitude.
out_valid  output  1  result c/ovf valid.
out_ready  input  1  downstream accepts result.
c  output  N  sum, sign-magnitude.
ovf  output  1  magnitude overflow flag for the current result.

Behaviour:
- Definitions: M = N-1 (magnitude width); K = ceil(M/W) (number of CALC cycles). The last chunk may be narrower than W.
- Reset (async, rst_n=0):
  - state = IDLE.
  - out_valid = 0, c = 0, ovf = 0.
  - All internal carry and operand registers cleared.
  - in_ready = 1 as soon as the state is IDLE, including while rst_n is held low.
  - Reset asserted mid-CALC or in DONE aborts the operation; no result is produced.
- in_ready = (state == IDLE). It is combinational from the state register only.
- State IDLE:
  - On in_valid && in_ready, capture the operands and go to CALC.
  - Operand ordering on capture:
    - Signs differ: place the larger magnitude in register X and the smaller in register Y. Set op = subtract and result sign = sign of the larger magnitude.
    - Signs equal: op = add, result sign = sa.
  - The magnitude compare is combinational at capture.
  - Equal magnitudes with different signs: op = subtract, result sign = 0.
- State CALC:
  - Runs for exactly K cycles.
  - Each cycle processes chunk i (LSB first): sum or difference of X and Y chunk i plus the carry/borrow register.
  - The chunk result is written into the result magnitude register. Carry/borrow is registered between chunks; the chunk counter runs 0..K-1.
  - After chunk K-1, go to DONE.
  - The final carry out of bit M-1 on an add sets ovf. The magnitude wraps modulo 2^M; there is no saturation.
  - Subtract never borrows out, because X >= Y; ovf = 0.
- State DONE:
  - out_valid = 1; c and ovf held stable.
  - On out_ready, go to IDLE and drop out_valid on the next edge.
  - No new operand is accepted in the same cycle as result retirement.
- Latency: operands accepted at edge t; out_valid is first visible after edge t+K. With defaults (K=4), that is 4 cycles.
- Throughput: one result per K+2 cycles at best.
- Zero rule:
  - A result magnitude of 0 always forces sign 0, so -0 is never output.
  - A -0 input is treated as magnitude 0 and follows the normal rules.
- c and ovf change only on entry to DONE or at reset. They hold their last value in IDLE/CALC.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored; the operands are not queued.

Test Plan:
- Same-sign add: a=0x0000C000 (+1.5), b=0x00012000 (+2.25) -> c=0x0001E000 (+3.75), ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Mixed sign, larger negative: a=0x00008000 (+1.0), b=0x80018000 (-3.0) -> c=0x80010000 (-2.0), ovf=0. Swapped (a=-3.0, b=+1.0) gives the same c.
- Cancellation: a=0x00008000, b=0x80008000 -> c=0x00000000 with sign 0. Also a=0x80000000 (-0), b=0x00000000 -> c=0x00000000.
- Overflow and wrap: a=0x7FFFFFFF, b=0x00000001 -> c=0x00000000, ovf=1. Also a=0xFFFFFFFF, b=0x80000002 -> c=0x80000001, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles while in DONE, pulsing in_valid with new operands -> c, ovf and out_valid stay stable, in_ready=0, and the new operands are dropped. Then out_ready=1 -> in_ready=1 on the next cycle.
- Reset mid-op: assert rst_n=0 asynchronously during CALC chunk 2 -> out_valid=0, c=0, ovf=0 immediately. After release, a fresh add of +1.0 + +1.0 gives c=0x00010000.
